branch_ctrl: RTL

//  Branch resolution sequencer for the EX stage of the 16-bit pipeline.

---
 rtl/branch_ctrl_pkg.sv | 32 +++
 rtl/branch_cond_eval.sv | 19 +
 rtl/branch_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared type codes, state encodings and the branch condition helper for branch_ctrl.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        BR_BEQZ = 2'b00,
        BR_BNEZ = 2'b01,
        BR_BLTZ = 2'b10,
        BR_BGEZ = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT     = 2'b01,
        S_REDIRECT = 2'b10,
        S_FLUSH    = 2'b11
    } state_e;

    localparam int CNT_W = 4;

    function automatic logic cond_taken(input logic zero, input logic neg, input logic [1:0] br_type);
        logic t;
        case (br_type)
            BR_BEQZ: t = zero;
            BR_BNEZ: t = !zero;
            BR_BLTZ: t = neg;
            BR_BGEZ: t = !neg;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation on the forwarded Rs operand.
module branch_cond_eval
    import branch_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rs_val,
    input  logic [1:0]       br_type,
    output logic             taken
);

    logic zero_s;
    logic neg_s;

    assign zero_s = (rs_val == {WIDTH{1'b0}});
    assign neg_s  = rs_val[WIDTH-1];
    assign taken  = cond_taken(zero_s, neg_s, br_type);

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution sequencer: operand wait, redirect and wrong-path flush.
// Optional BRANCH_STATS_EN adds br_total/br_taken accept counters.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             rs_ready,
    input  logic [WIDTH-1:0] pc_plus2,
    input  logic [WIDTH-1:0] imm,
`ifdef BRANCH_STATS_EN
    output logic [15:0]      br_total,
    output logic [15:0]      br_taken,
`endif
    output logic             br_accept,
    output logic             stall,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic             busy
);

    state_e           state_r;
    state_e           next_state_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] redirect_pc_r;
    logic [WIDTH-1:0] target_s;
    logic             taken_s;
    logic             accept_s;
    logic             stall_s;
    logic             load_target_s;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .rs_val  (rs_val),
        .br_type (br_type),
        .taken   (taken_s)
    );

    // Carry out of the target add is intentionally dropped so targets wrap.
    assign target_s = pc_plus2 + imm;

    // Next-state and same-cycle handshake decode; held quiet while reset is asserted.
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        stall_s       = 1'b0;
        load_target_s = 1'b0;
        if (rst) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_WAIT: begin
                    if (!br_valid) begin
                        next_state_s = S_IDLE;
                    end else if (!rs_ready) begin
                        stall_s      = 1'b1;
                        next_state_s = S_WAIT;
                    end else begin
                        accept_s = 1'b1;
                        if (taken_s) begin
                            load_target_s = 1'b1;
                            next_state_s  = S_REDIRECT;
                        end else begin
                            next_state_s = S_IDLE;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (FLUSH_CYCLES > 1) begin
                        next_state_s = S_FLUSH;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                // Redirect already covered one flush cycle, so leave on the last count.
                S_FLUSH: begin
                    if (count_r <= 4'd1) begin
                        next_state_s = S_IDLE;
                    end else begin
                        next_state_s = S_FLUSH;
                    end
                end
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // State, flush counter and registered redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            count_r       <= 4'd0;
            redirect_pc_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (load_target_s) begin
                redirect_pc_r <= target_s;
            end
            if (state_r == S_REDIRECT) begin
                count_r <= CNT_W'(FLUSH_CYCLES - 1);
            end else if ((state_r == S_FLUSH) && (count_r != 4'd0)) begin
                count_r <= count_r - 4'd1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] br_total_r;
    logic [15:0] br_taken_r;

    // Accept statistics; both counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_total_r <= 16'd0;
            br_taken_r <= 16'd0;
        end else begin
            if (accept_s) begin
                br_total_r <= br_total_r + 16'd1;
            end
            if (accept_s && taken_s) begin
                br_taken_r <= br_taken_r + 16'd1;
            end
        end
    end

    assign br_total = br_total_r;
    assign br_taken = br_taken_r;
`endif

    assign br_accept   = accept_s;
    assign stall       = stall_s;
    assign redirect    = (state_r == S_REDIRECT);
    assign flush       = (state_r == S_REDIRECT) || (state_r == S_FLUSH);
    assign busy        = (state_r != S_IDLE);
    assign redirect_pc = redirect_pc_r;

endmodule
